// File: rtl/eb_gray_pointer.sv
// Gray-coded pointer unit for one side of the PCS RX elastic buffer.
// Registered binary/Gray pointer pair with step/hold/jump control, remote pointer decode and fill-level flags.
module eb_gray_pointer #(
    parameter int ADDR_WIDTH = 4,
    parameter int MODE       = 0,
    parameter int HI_THRESH  = 12,
    parameter int LO_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  hold,
    input  logic                  jump,
    input  logic [ADDR_WIDTH:0]   remote_gray,
    output logic [ADDR_WIDTH:0]   bin_ptr,
    output logic [ADDR_WIDTH:0]   gray_ptr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   remote_bin,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  busy,
    output logic                  full,
    output logic                  empty,
    output logic                  level_hi,
    output logic                  level_lo,
    output logic                  err
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] HI_V    = PTR_W'(HI_THRESH);
    localparam logic [PTR_W-1:0] LO_V    = PTR_W'(LO_THRESH);

    // ST_JUMP means the second step of an accepted jump is owed this cycle.
    typedef enum logic {ST_IDLE = 1'b0, ST_JUMP = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] bin_d;
    logic [PTR_W-1:0] gray_q;
    logic [PTR_W-1:0] remote_bin_q;
    logic [PTR_W-1:0] level_q;
    logic [PTR_W-1:0] level_d;
    logic             err_q;
    logic             adv;

    function automatic logic [PTR_W-1:0] to_gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] to_bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b = '0;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_JUMP: state_d = ST_IDLE;
                default: if (inc && jump && !hold) state_d = ST_JUMP;
            endcase
        end
    end

    // A pending jump step wins over hold/inc; clr discards everything.
    always_comb begin
        adv = 1'b0;
        if (state_q == ST_JUMP) begin
            adv = 1'b1;
        end else if (!hold && inc) begin
            adv = 1'b1;
        end
        bin_d = clr ? '0 : bin_q + PTR_W'(adv);
    end

    always_comb begin
        if (MODE == 0) begin
            level_d = bin_q - remote_bin_q;
        end else begin
            level_d = remote_bin_q - bin_q;
        end
    end

    // Gray is taken from the next binary value so it never lags bin_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q        <= '0;
            gray_q       <= '0;
            remote_bin_q <= '0;
            level_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            bin_q        <= bin_d;
            gray_q       <= to_gray(bin_d);
            remote_bin_q <= to_bin(remote_gray);
            level_q      <= level_d;
            err_q        <= clr ? 1'b0 : (err_q | (level_d > DEPTH_V));
        end
    end

    always_comb begin
        busy       = (state_q == ST_JUMP);
        bin_ptr    = bin_q;
        gray_ptr   = gray_q;
        addr       = bin_q[ADDR_WIDTH-1:0];
        remote_bin = remote_bin_q;
        level      = level_q;
        err        = err_q;
        full       = (level_q == DEPTH_V);
        empty      = (level_q == '0);
        level_hi   = (level_q >= HI_V);
        level_lo   = (level_q <= LO_V);
    end

endmodule

// File: tb/tb_eb_gray_pointer.sv
// Bench for eb_gray_pointer: a write-side and a read-side instance share stimulus and are
// compared every cycle against an arithmetic pointer/level model, with literal pins per scenario.
module tb_eb_gray_pointer;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int PMASK = (1 << PW) - 1;
    localparam int DEPTH = 1 << AW;
    localparam int HI    = 12;
    localparam int LO    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          inc = 1'b0;
    logic          hold = 1'b0;
    logic          jump = 1'b0;
    logic [PW-1:0] remote_gray = '0;

    logic [PW-1:0] bin_ptr [2];
    logic [PW-1:0] gray_ptr [2];
    logic [AW-1:0] addr [2];
    logic [PW-1:0] remote_bin [2];
    logic [PW-1:0] level [2];
    logic          busy [2];
    logic          full [2];
    logic          empty [2];
    logic          level_hi [2];
    logic          level_lo [2];
    logic          err [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model state: plain integers, pointer arithmetic modulo 2**PW.
    int m_ptr = 0;
    bit m_pend = 1'b0;
    int m_rb = 0;
    int m_lvl [2] = '{0, 0};
    bit m_err [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    for (genvar md = 0; md < 2; md++) begin : g_dut
        eb_gray_pointer #(
            .ADDR_WIDTH(AW), .MODE(md), .HI_THRESH(HI), .LO_THRESH(LO)
        ) dut (
            .clk(clk), .rst(rst), .clr(clr), .inc(inc), .hold(hold), .jump(jump),
            .remote_gray(remote_gray),
            .bin_ptr(bin_ptr[md]), .gray_ptr(gray_ptr[md]), .addr(addr[md]),
            .remote_bin(remote_bin[md]), .level(level[md]), .busy(busy[md]),
            .full(full[md]), .empty(empty[md]), .level_hi(level_hi[md]),
            .level_lo(level_lo[md]), .err(err[md])
        );
    end

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & PMASK;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit i, input bit h,
                                input bit j, input int rv);
        int nl;
        if (r) begin
            m_ptr = 0; m_pend = 0; m_rb = 0;
            m_lvl = '{0, 0}; m_err = '{1'b0, 1'b0};
        end else begin
            for (int md = 0; md < 2; md++) begin
                nl = (md == 0) ? ((m_ptr - m_rb) & PMASK) : ((m_rb - m_ptr) & PMASK);
                m_err[md] = c ? 1'b0 : (m_err[md] | (nl > DEPTH));
                m_lvl[md] = nl;
            end
            m_rb = rv & PMASK;
            if (c) begin
                m_ptr = 0; m_pend = 0;
            end else if (m_pend) begin
                m_ptr = (m_ptr + 1) & PMASK; m_pend = 0;
            end else if (!h && i) begin
                m_ptr = (m_ptr + 1) & PMASK; m_pend = j;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic step(input bit r, input bit c, input bit i, input bit h,
                        input bit j, input int rv);
        rst = r; clr = c; inc = i; hold = h; jump = j;
        remote_gray = PW'(gray_of(rv));
        @(posedge clk);
        model_update(r, c, i, h, j, rv);
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int md = 0; md < 2; md++) begin
                chk($sformatf("bin%0d", md), int'(bin_ptr[md]), m_ptr);
                chk($sformatf("gray%0d", md), int'(gray_ptr[md]), gray_of(m_ptr));
                chk($sformatf("addr%0d", md), int'(addr[md]), m_ptr % DEPTH);
                chk($sformatf("rbin%0d", md), int'(remote_bin[md]), m_rb);
                chk($sformatf("level%0d", md), int'(level[md]), m_lvl[md]);
                chk($sformatf("busy%0d", md), int'(busy[md]), int'(m_pend));
                chk($sformatf("full%0d", md), int'(full[md]), int'(m_lvl[md] == DEPTH));
                chk($sformatf("empty%0d", md), int'(empty[md]), int'(m_lvl[md] == 0));
                chk($sformatf("hi%0d", md), int'(level_hi[md]), int'(m_lvl[md] >= HI));
                chk($sformatf("lo%0d", md), int'(level_lo[md]), int'(m_lvl[md] <= LO));
                chk($sformatf("err%0d", md), int'(err[md]), int'(m_err[md]));
            end
        end
    end

    initial begin
        int prev_gray;
        int rv;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_bin", int'(bin_ptr[0]), 0);
        chk("rst_empty", int'(empty[0]), 1);
        chk("rst_lo", int'(level_lo[0]), 1);
        chk("rst_full", int'(full[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);

        // 40 incs: count through the wrap, one Gray bit per step
        prev_gray = int'(gray_ptr[0]);
        for (int k = 1; k <= 40; k++) begin
            step(0, 0, 1, 0, 0, 0);
            chk("gray_onebit", $countones(int'(gray_ptr[0]) ^ prev_gray), 1);
            prev_gray = int'(gray_ptr[0]);
            if (k == 31) chk("gray_at_31", int'(gray_ptr[0]), 'h10);
        end
        chk("wrap_bin", int'(bin_ptr[0]), 8);

        // Write side filling against a parked remote pointer
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("w_level16", int'(level[0]), 16);
        chk("w_full", int'(full[0]), 1);
        chk("w_hi", int'(level_hi[0]), 1);
        chk("w_err_clean", int'(err[0]), 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("w_level17", int'(level[0]), 17);
        chk("w_err_set", int'(err[0]), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("w_err_sticky", int'(err[0]), 1);
        step(0, 1, 0, 0, 0, 0);
        chk("w_err_clr", int'(err[0]), 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("w_err_stays", int'(err[0]), 0);

        // Read side: remote walks 0..10, then the local side catches up
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k <= 10; k++) begin
            step(0, 0, 0, 0, 0, k);
            chk("r_rbin_lag", int'(remote_bin[1]), k);
        end
        step(0, 0, 0, 0, 0, 10);
        chk("r_level10", int'(level[1]), 10);
        chk("r_lo_off", int'(level_lo[1]), 0);
        for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 0, 10);
        step(0, 0, 0, 0, 0, 10);
        chk("r_empty", int'(empty[1]), 1);

        // Jump at 5, with an inc during the busy cycle that must be ignored
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        chk("j_first", int'(bin_ptr[0]), 6);
        chk("j_busy", int'(busy[0]), 1);
        step(0, 0, 1, 0, 1, 0);
        chk("j_second", int'(bin_ptr[0]), 7);
        chk("j_busy_off", int'(busy[0]), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("j_final", int'(bin_ptr[0]), 7);

        // hold beats inc; jump alone does nothing
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 0);
        chk("hold_ptr", int'(bin_ptr[0]), 7);
        step(0, 0, 0, 0, 1, 0);
        chk("jump_alone", int'(bin_ptr[0]), 7);
        chk("jump_alone_busy", int'(busy[0]), 0);

        // Mid-jump reset
        step(0, 0, 1, 0, 1, 3);
        step(1, 0, 0, 0, 0, 3);
        chk("mj_rst_bin", int'(bin_ptr[0]), 0);
        chk("mj_rst_busy", int'(busy[0]), 0);
        chk("mj_rst_level", int'(level[1]), 0);

        // Mid-jump clr: pointer flushes, level recomputes against remote 3
        step(0, 0, 1, 0, 0, 3);
        step(0, 0, 1, 0, 1, 3);
        step(0, 1, 1, 0, 0, 3);
        chk("mj_clr_bin", int'(bin_ptr[0]), 0);
        chk("mj_clr_busy", int'(busy[0]), 0);
        step(0, 0, 0, 0, 0, 3);
        chk("mj_clr_level1", int'(level[1]), 3);
        chk("mj_clr_level0", int'(level[0]), 29);

        // Randomised traffic
        rv = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) rv = (rv + 1) & PMASK;
            if ($urandom_range(0, 99) == 0) rv = int'($urandom_range(0, PMASK));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, rv);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eb_gray_pointer.md
# eb_gray_pointer

Parametrised Gray-coded pointer unit for the PCS RX elastic buffer: one instance per buffer side (write or read). Keeps a registered binary/Gray pointer pair with single-step, hold and skip-jump control, converts the synchronised remote Gray pointer back to binary, and produces a registered fill level plus full/empty/threshold/error flags. It replaces the stand-alone combinational binary-to-Gray conversion and gives SKP insertion/deletion logic the control it needs.

## Interface

- ADDR_WIDTH, 4, buffer address width; DEPTH = 2**ADDR_WIDTH; pointer width PTR_W = ADDR_WIDTH+1
- MODE, 0, 0 = write side (level = local - remote), 1 = read side (level = remote - local)
- HI_THRESH, 12, level_hi asserted when level >= HI_THRESH; legal range 1..DEPTH
- LO_THRESH, 4, level_lo asserted when level <= LO_THRESH; legal range 0..HI_THRESH-1

- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush of the local pointer
- inc  in  1  advance the local pointer by 1
- hold  in  1  suppress advance this cycle (SKP insert on the read side)
- jump  in  1  with inc: advance by 2 over two cycles (SKP delete)
- remote_gray  in  PTR_W  already-synchronised Gray pointer from the other domain
- bin_ptr  out  PTR_W  registered binary pointer
- gray_ptr  out  PTR_W  registered Gray pointer; always the Gray code of bin_ptr
- addr  out  ADDR_WIDTH  bin_ptr[ADDR_WIDTH-1:0]
- remote_bin  out  PTR_W  registered binary of remote_gray
- level  out  PTR_W  registered fill level
- busy  out  1  second step of a jump is pending; inputs are ignored
- full, empty, level_hi, level_lo  out  1  decoded from level
- err  out  1  sticky: level > DEPTH observed

## Operation

- Gray code: g[i] = b[i] ^ b[i+1] for i < PTR_W-1; g[PTR_W-1] = b[PTR_W-1]. gray_ptr is registered from the Gray code of the next binary value, so it never lags bin_ptr.
- Gray-to-binary: b[PTR_W-1] = g[PTR_W-1]; b[i] = b[i+1] ^ g[i].
- Per-edge priority: rst > clr > busy > hold > inc.
  - rst: bin_ptr, gray_ptr, remote_bin, level, busy and err go to 0.
  - clr: bin_ptr, gray_ptr, busy and err go to 0; remote_bin and level keep updating.
  - busy = 1: pointer +1, busy goes to 0; inc, hold and jump are ignored.
  - hold = 1: pointer unchanged.
  - inc & jump: pointer +1, busy goes to 1.
  - inc & !jump: pointer +1.
  - Otherwise: pointer unchanged.
- jump without inc has no effect.
- The pointer changes by at most 1 per cycle, so gray_ptr changes by exactly 0 or 1 bit per edge. This is CDC-safe.
- Pointer arithmetic is modulo 2**PTR_W. Wrap from 2**PTR_W-1 to 0 is silent.
- Level update, modulo 2**PTR_W, using the current register values:
  - MODE 0: level <= bin_ptr - remote_bin
  - MODE 1: level <= remote_bin - bin_ptr
- Flag decode from the level register (combinational): full = (level == DEPTH); empty = (level == 0); level_hi = (level >= HI_THRESH); level_lo = (level <= LO_THRESH).
- err sets when level > DEPTH and holds until rst or clr.

## Timing

- Reset values: all pointers and level = 0, busy = 0, err = 0, full = 0, empty = 1, level_hi = 0, level_lo = 1.
- inc sampled at edge N: bin_ptr, gray_ptr and addr show the new value after edge N (latency 1).
- Jump accepted at edge N: +1 after edge N, busy high during cycle N+1, second +1 after edge N+1.
- remote_gray to remote_bin: latency 1 cycle. remote_gray to level: latency 2 cycles.
- Local inc to level: latency 2 cycles (one for the pointer, one for the level register).
- clr with busy = 1: the pending step is discarded.
- clr and inc together: the pointer goes to 0; inc is lost.

## Test plan

- Reset, then 40 inc pulses with ADDR_WIDTH = 4: bin_ptr counts 0..31 then wraps to 8; each gray_ptr step differs by exactly one bit; gray_ptr = 0x10 when bin_ptr = 31.
- MODE 0, remote_gray held at 0, 16 incs: level reaches 16 two cycles after the last inc, full = 1, level_hi = 1. A 17th inc makes level = 17 and err = 1 (sticky). clr then returns err to 0.
- MODE 1, remote_gray driven as Gray codes of 0..10, local held: remote_bin tracks with 1-cycle lag, level = 10, level_lo = 0. Then 10 incs: empty = 1.
- Jump at bin_ptr = 5: bin_ptr reads 6 (busy = 1), then 7. An inc asserted during the busy cycle is ignored, so the pointer ends at 7, not 8.
- hold and inc together for 3 cycles: the pointer is unchanged. jump alone: the pointer is unchanged and busy stays 0.
- Mid-jump rst, and separately mid-jump clr: next cycle bin_ptr = 0 and busy = 0. After rst, level = 0; after clr, level recomputes against remote_bin.
